// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port integer register file.
// Widths here are the defaults; modules take the real widths as parameters.
package regfile_pkg;

  localparam int DEF_DATAWIDTH = 32;
  localparam int DEF_ADDRWIDTH = 5;

  localparam int REG_ZERO   = 0;
  localparam int A0_IDX_DEF = 10;
  // Program-input injection targets (trigger and random value registers).
  localparam int T0_IDX     = 5;
  localparam int T4_IDX     = 29;

  typedef logic [DEF_ADDRWIDTH-1:0] reg_addr_t;
  typedef logic [DEF_DATAWIDTH-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set on issue, cleared on writeback, issue wins a tie.
// Read ports see a register as free while it is being written (its data is bypassed).
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDRWIDTH = DEF_ADDRWIDTH,
  parameter int NR        = 2,
  parameter int NW        = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    iss_valid,
  input  logic [ADDRWIDTH-1:0]    iss_rd,
  input  logic [NW-1:0]           wr_en,
  input  logic [NW*ADDRWIDTH-1:0] wr_addr,
  input  logic [NR*ADDRWIDTH-1:0] rd_addr,
  output logic [NR-1:0]           rd_busy
);

  localparam int DEPTH = 1 << ADDRWIDTH;

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic [DEPTH-1:0] wr_hit;

  // NOTE: every always_comb variable gets a default before any conditional
  // assignment, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_hit = '0;
    for (int j = 0; j < NW; j++) begin
      if (wr_en[j]) wr_hit[wr_addr[j*ADDRWIDTH +: ADDRWIDTH]] = 1'b1;
    end
  end

  always_comb begin
    busy_nxt = busy & ~wr_hit;
    if (iss_valid) busy_nxt[iss_rd] = 1'b1;
    busy_nxt[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  always_comb begin
    rd_busy = '0;
    for (int i = 0; i < NR; i++) begin
      rd_busy[i] = busy[rd_addr[i*ADDRWIDTH +: ADDRWIDTH]]
                 & ~wr_hit[rd_addr[i*ADDRWIDTH +: ADDRWIDTH]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port RV32I register file: NR bypassed combinational reads, NW posedge
// writes, one low-priority injection port, scoreboard, registered a0 and debug read.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int ADDRWIDTH = DEF_ADDRWIDTH,
  parameter int NR        = 2,
  parameter int NW        = 2,
  parameter int A0_IDX    = A0_IDX_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NR*ADDRWIDTH-1:0] rd_addr,
  output logic [NR*DATAWIDTH-1:0] rd_data,
  output logic [NR-1:0]           rd_busy,
  input  logic [NW-1:0]           wr_en,
  input  logic [NW*ADDRWIDTH-1:0] wr_addr,
  input  logic [NW*DATAWIDTH-1:0] wr_data,
  input  logic                    iss_valid,
  input  logic [ADDRWIDTH-1:0]    iss_rd,
  input  logic                    inj_valid,
  input  logic [ADDRWIDTH-1:0]    inj_addr,
  input  logic [DATAWIDTH-1:0]    inj_data,
  output logic [DATAWIDTH-1:0]    a0,
  input  logic [ADDRWIDTH-1:0]    dbg_addr,
  output logic [DATAWIDTH-1:0]    dbg_data
);

  localparam int                   DEPTH   = 1 << ADDRWIDTH;
  localparam logic [ADDRWIDTH-1:0] ZERO    = ADDRWIDTH'(REG_ZERO);
  localparam logic [ADDRWIDTH-1:0] A0_ADDR = ADDRWIDTH'(A0_IDX);

  logic [DATAWIDTH-1:0] mem [DEPTH];
  logic [ADDRWIDTH-1:0] ra;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the array is reset on purpose: cleared registers are visible to
      // software after reset, so this cannot be mapped onto a plain RAM macro.
      for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
      a0 <= '0;
    end else begin
      a0 <= mem[A0_ADDR];
      if (inj_valid && inj_addr != ZERO) mem[inj_addr] <= inj_data;
      // NOTE: non-blocking updates take effect in program order at the edge, so
      // the last one scheduled (highest write port) wins a same-address collision.
      for (int j = 0; j < NW; j++) begin
        if (wr_en[j] && wr_addr[j*ADDRWIDTH +: ADDRWIDTH] != ZERO)
          mem[wr_addr[j*ADDRWIDTH +: ADDRWIDTH]] <= wr_data[j*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

  // Later assignments override earlier ones: array < injection < write ports.
  always_comb begin
    rd_data = '0;
    ra      = '0;
    for (int i = 0; i < NR; i++) begin
      ra = rd_addr[i*ADDRWIDTH +: ADDRWIDTH];
      if (ra != ZERO) begin
        rd_data[i*DATAWIDTH +: DATAWIDTH] = mem[ra];
        if (inj_valid && inj_addr == ra) rd_data[i*DATAWIDTH +: DATAWIDTH] = inj_data;
        for (int j = 0; j < NW; j++) begin
          if (wr_en[j] && wr_addr[j*ADDRWIDTH +: ADDRWIDTH] == ra)
            rd_data[i*DATAWIDTH +: DATAWIDTH] = wr_data[j*DATAWIDTH +: DATAWIDTH];
        end
      end
    end
  end

  assign dbg_data = (dbg_addr == ZERO) ? '0 : mem[dbg_addr];

  regfile_scoreboard #(
    .ADDRWIDTH (ADDRWIDTH),
    .NR        (NR),
    .NW        (NW)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .rd_addr   (rd_addr),
    .rd_busy   (rd_busy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized traffic
// compared against a behavioural array/scoreboard model.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int A0 = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic [NW-1:0]     wr_en;
  logic [NW*AW-1:0]  wr_addr;
  logic [NW*DW-1:0]  wr_data;
  logic              iss_valid;
  reg_addr_t         iss_rd;
  logic              inj_valid;
  reg_addr_t         inj_addr;
  reg_data_t         inj_data;
  reg_data_t         a0;
  reg_addr_t         dbg_addr;
  reg_data_t         dbg_data;

  int n_cmp = 0;
  int n_bad = 0;

  reg_data_t m_mem [32];
  logic      m_busy[32];
  reg_data_t m_a0;

  regfile_mp #(
    .DATAWIDTH (DW), .ADDRWIDTH (AW), .NR (NR), .NW (NW), .A0_IDX (A0)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .rd_addr (rd_addr), .rd_data (rd_data), .rd_busy (rd_busy),
    .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
    .iss_valid (iss_valid), .iss_rd (iss_rd),
    .inj_valid (inj_valid), .inj_addr (inj_addr), .inj_data (inj_data),
    .a0 (a0), .dbg_addr (dbg_addr), .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_mem[r]  = '0;
      m_busy[r] = 1'b0;
    end
    m_a0 = '0;
  endtask

  function automatic reg_data_t exp_rd(input reg_addr_t a);
    if (a == 0) return '0;
    for (int j = NW - 1; j >= 0; j--)
      if (wr_en[j] && wr_addr[j*AW +: AW] == a) return wr_data[j*DW +: DW];
    if (inj_valid && inj_addr == a) return inj_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input reg_addr_t a);
    if (a == 0) return 1'b0;
    for (int j = 0; j < NW; j++)
      if (wr_en[j] && wr_addr[j*AW +: AW] == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic model_edge();
    reg_data_t old_a0;
    reg_addr_t wa;
    old_a0 = m_mem[A0];
    if (inj_valid && inj_addr != 0) m_mem[inj_addr] = inj_data;
    for (int j = 0; j < NW; j++) begin
      wa = wr_addr[j*AW +: AW];
      if (wr_en[j] && wa != 0) begin
        m_mem[wa]  = wr_data[j*DW +: DW];
        m_busy[wa] = 1'b0;
      end
    end
    if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
    m_a0 = old_a0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    iss_valid = 1'b0; iss_rd = '0;
    inj_valid = 1'b0; inj_addr = '0; inj_data = '0;
    dbg_addr = '0;
  endtask

  task automatic wr(input int port, input reg_addr_t a, input reg_data_t d);
    wr_en[port]          = 1'b1;
    wr_addr[port*AW +: AW] = a;
    wr_data[port*DW +: DW] = d;
  endtask

  function automatic reg_addr_t raddr();
    if ($urandom_range(0, 3) == 0) return reg_addr_t'(A0);
    return reg_addr_t'($urandom_range(0, 7));
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle();
    rd_addr = {5'd4, 5'd10};
    dbg_addr = 5'd10;
    #1;
    n_cmp++; if (rd_data !== '0) begin n_bad++; $display("FAIL reset_rd: got %h expected 0", rd_data); end
    n_cmp++; if (rd_busy !== '0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", rd_busy); end
    n_cmp++; if (a0 !== '0) begin n_bad++; $display("FAIL reset_a0: got %h expected 0", a0); end
    // Load x3 and mark it busy, then reset mid-cycle.
    idle();
    wr(0, 5'd3, 32'hDEADBEEF);
    iss_valid = 1'b1; iss_rd = 5'd3;
    tick();
    idle();
    rd_addr[0 +: AW] = 5'd3; dbg_addr = 5'd3;
    #1;
    n_cmp++; if (rd_data[0 +: DW] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL prereset_x3: got %h expected deadbeef", rd_data[0 +: DW]); end
    n_cmp++; if (rd_busy[0] !== 1'b1) begin n_bad++; $display("FAIL prereset_busy: got %b expected 1", rd_busy[0]); end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (rd_data[0 +: DW] !== '0) begin n_bad++; $display("FAIL async_reset_x3: got %h expected 0", rd_data[0 +: DW]); end
    n_cmp++; if (dbg_data !== '0) begin n_bad++; $display("FAIL async_reset_dbg: got %h expected 0", dbg_data); end
    n_cmp++; if (rd_busy[0] !== 1'b0) begin n_bad++; $display("FAIL async_reset_busy: got %b expected 0", rd_busy[0]); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_zero();
    idle();
    wr(0, 5'd0, 32'h1234);
    iss_valid = 1'b1; iss_rd = 5'd0;
    rd_addr = {5'd0, 5'd0};
    #1;
    n_cmp++; if (rd_data[0 +: DW] !== '0) begin n_bad++; $display("FAIL x0_bypass: got %h expected 0", rd_data[0 +: DW]); end
    tick();
    idle();
    #1;
    n_cmp++; if (rd_data[DW +: DW] !== '0) begin n_bad++; $display("FAIL x0_after: got %h expected 0", rd_data[DW +: DW]); end
    n_cmp++; if (rd_busy !== '0) begin n_bad++; $display("FAIL x0_busy: got %b expected 0", rd_busy); end
  endtask

  task automatic test_bypass();
    idle();
    wr(0, 5'd7, 32'h0000_0077);
    tick();
    idle();
    rd_addr[0 +: AW] = 5'd7; dbg_addr = 5'd7;
    wr(1, 5'd7, 32'hA5A5A5A5);
    #1;
    n_cmp++; if (rd_data[0 +: DW] !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL bypass_x7: got %h expected a5a5a5a5", rd_data[0 +: DW]); end
    n_cmp++; if (dbg_data !== 32'h77) begin n_bad++; $display("FAIL dbg_nobypass_x7: got %h expected 77", dbg_data); end
    tick();
    idle();
    wr(0, 5'd9, 32'h11);
    wr(1, 5'd9, 32'h22);
    rd_addr[DW/DW*AW +: AW] = 5'd9;
    dbg_addr = 5'd7;
    #1;
    n_cmp++; if (dbg_data !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL dbg_x7_after: got %h expected a5a5a5a5", dbg_data); end
    n_cmp++; if (rd_data[DW +: DW] !== 32'h22) begin n_bad++; $display("FAIL bypass_x9_dual: got %h expected 22", rd_data[DW +: DW]); end
    tick();
    idle();
    dbg_addr = 5'd9;
    #1;
    n_cmp++; if (dbg_data !== 32'h22) begin n_bad++; $display("FAIL dual_write_x9: got %h expected 22", dbg_data); end
  endtask

  task automatic test_inject();
    idle();
    inj_valid = 1'b1; inj_addr = reg_addr_t'(T0_IDX); inj_data = 32'h1;
    wr(0, reg_addr_t'(T0_IDX), 32'h7);
    tick();
    idle();
    inj_valid = 1'b1; inj_addr = reg_addr_t'(T4_IDX); inj_data = 32'h3C;
    rd_addr[0 +: AW] = reg_addr_t'(T4_IDX);
    dbg_addr = reg_addr_t'(T0_IDX);
    #1;
    n_cmp++; if (dbg_data !== 32'h7) begin n_bad++; $display("FAIL inject_prio_x5: got %h expected 7", dbg_data); end
    n_cmp++; if (rd_data[0 +: DW] !== 32'h3C) begin n_bad++; $display("FAIL inject_bypass_x29: got %h expected 3c", rd_data[0 +: DW]); end
    tick();
    idle();
    dbg_addr = reg_addr_t'(T4_IDX);
    #1;
    n_cmp++; if (dbg_data !== 32'h3C) begin n_bad++; $display("FAIL inject_x29: got %h expected 3c", dbg_data); end
  endtask

  task automatic test_scoreboard();
    idle();
    iss_valid = 1'b1; iss_rd = 5'd12;
    rd_addr[AW +: AW] = 5'd12;
    #1;
    n_cmp++; if (rd_busy[1] !== 1'b0) begin n_bad++; $display("FAIL busy_before_issue: got %b expected 0", rd_busy[1]); end
    tick();
    idle();
    rd_addr[AW +: AW] = 5'd12;
    #1;
    n_cmp++; if (rd_busy[1] !== 1'b1) begin n_bad++; $display("FAIL busy_after_issue: got %b expected 1", rd_busy[1]); end
    wr(0, 5'd12, 32'hC0);
    iss_valid = 1'b1; iss_rd = 5'd12;
    tick();
    idle();
    rd_addr[AW +: AW] = 5'd12;
    #1;
    n_cmp++; if (rd_busy[1] !== 1'b1) begin n_bad++; $display("FAIL busy_set_wins: got %b expected 1", rd_busy[1]); end
    wr(1, 5'd12, 32'hC1);
    #1;
    n_cmp++; if (rd_busy[1] !== 1'b0) begin n_bad++; $display("FAIL busy_during_write: got %b expected 0", rd_busy[1]); end
    tick();
    idle();
    rd_addr[0 +: AW] = 5'd12;
    #1;
    n_cmp++; if (rd_busy[0] !== 1'b0) begin n_bad++; $display("FAIL busy_cleared: got %b expected 0", rd_busy[0]); end
  endtask

  task automatic test_a0();
    reg_data_t prev;
    idle();
    prev = m_mem[A0];
    wr(0, reg_addr_t'(A0), 32'h55);
    tick();
    idle();
    #1;
    n_cmp++; if (a0 !== prev) begin n_bad++; $display("FAIL a0_early: got %h expected %h", a0, prev); end
    tick();
    #1;
    n_cmp++; if (a0 !== 32'h55) begin n_bad++; $display("FAIL a0_late: got %h expected 55", a0); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      idle();
      for (int i = 0; i < NR; i++) rd_addr[i*AW +: AW] = raddr();
      for (int j = 0; j < NW; j++) begin
        wr_en[j]             = ($urandom_range(0, 2) == 0);
        wr_addr[j*AW +: AW]  = raddr();
        wr_data[j*DW +: DW]  = $urandom;
      end
      iss_valid = $urandom_range(0, 1) == 1;
      iss_rd    = raddr();
      inj_valid = ($urandom_range(0, 3) == 0);
      inj_addr  = raddr();
      inj_data  = $urandom;
      dbg_addr  = raddr();
      #1;
      for (int i = 0; i < NR; i++) begin
        n_cmp++;
        if (rd_data[i*DW +: DW] !== exp_rd(rd_addr[i*AW +: AW])) begin
          n_bad++;
          $display("FAIL rand_rd%0d cyc %0d addr %0d: got %h expected %h", i, c,
                   rd_addr[i*AW +: AW], rd_data[i*DW +: DW], exp_rd(rd_addr[i*AW +: AW]));
        end
        n_cmp++;
        if (rd_busy[i] !== exp_busy(rd_addr[i*AW +: AW])) begin
          n_bad++;
          $display("FAIL rand_busy%0d cyc %0d addr %0d: got %b expected %b", i, c,
                   rd_addr[i*AW +: AW], rd_busy[i], exp_busy(rd_addr[i*AW +: AW]));
        end
      end
      n_cmp++;
      if (dbg_data !== m_mem[dbg_addr]) begin
        n_bad++;
        $display("FAIL rand_dbg cyc %0d addr %0d: got %h expected %h", c, dbg_addr, dbg_data, m_mem[dbg_addr]);
      end
      n_cmp++;
      if (a0 !== m_a0) begin
        n_bad++;
        $display("FAIL rand_a0 cyc %0d: got %h expected %h", c, a0, m_a0);
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    test_reset();
    test_zero();
    test_bypass();
    test_inject();
    test_scoreboard();
    test_a0();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the pipelined RV32I core. Replaces the single-write, negedge-clocked register file.
- Provides NR combinational read ports with write-first bypass and NW posedge write ports.
- Holds a per-register scoreboard (busy bits) for hazard detection, plus a single external-injection port for program inputs (F1 trigger/random values).
- Sits between decode (reads, issue) and writeback (writes).

Parameters:
- DATAWIDTH, 32, register width in bits
- ADDRWIDTH, 5, address width; DEPTH = 2**ADDRWIDTH
- NR, 2, number of read ports (1..4)
- NW, 2, number of write ports (1..2)
- A0_IDX, 10, register index exported on a0

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_addr  in  NR*ADDRWIDTH  read addresses, port i at slice i
- rd_data  out  NR*DATAWIDTH  read data, port i at slice i
- rd_busy  out  NR  scoreboard busy flag for rd_addr[i]
- wr_en  in  NW  write enables
- wr_addr  in  NW*ADDRWIDTH  write addresses
- wr_data  in  NW*DATAWIDTH  write data
- iss_valid  in  1  instruction issued with destination iss_rd
- iss_rd  in  ADDRWIDTH  destination register of issued instruction
- inj_valid  in  1  external program-input write request
- inj_addr  in  ADDRWIDTH  injection target register
- inj_data  in  DATAWIDTH  injection data
- a0  out  DATAWIDTH  registered copy of register A0_IDX
- dbg_addr  in  ADDRWIDTH  debug read address
- dbg_data  out  DATAWIDTH  raw array contents at dbg_addr, no bypass

Behaviour:
- Clocking and reset: one clock (clk); reset asynchronous active-low (rst_n).
- Reset (rst_n=0, asynchronous): all registers, all busy bits and a0 clear to 0. Combinational outputs follow from the cleared state. Reset mid-operation discards in-flight writes and scoreboard state.
- Register 0: always reads 0 and is never busy. Writes, injections and issues targeting 0 are ignored.
- Writes: on rising clk, each port j with wr_en[j]=1 and wr_addr[j]!=0 stores wr_data[j].
  - Two ports, same address, same cycle: the higher-index port wins.
- Injection: on rising clk, if inj_valid=1 and inj_addr!=0, store inj_data.
  - Lower priority than any write port hitting the same address in the same cycle.
  - Does not touch busy bits.
- Read (combinational, zero latency): rd_data[i] is resolved in this order:
  - addr 0 -> 0;
  - else highest-index write port with wr_en and matching address -> its wr_data;
  - else inj_valid with matching inj_addr -> inj_data;
  - else array contents.
- Scoreboard: busy[r] set on rising clk when iss_valid=1 and iss_rd=r!=0. busy[r] cleared when any write port writes r.
  - Set and clear of the same r in the same cycle: set wins (a newer producer is in flight).
- rd_busy[i] = busy[rd_addr[i]] and not (a write port writes rd_addr[i] this cycle), so bypassed data is reported not-busy.
- a0: registered. It is updated the cycle after register A0_IDX changes, i.e. it equals the array content at A0_IDX one edge late.
- dbg_data: pure array read, no bypass. Address 0 reads 0.
- Width rules: no arithmetic. Address decoding is a full DEPTH decode; out-of-range addresses cannot occur.

Decomposition:
- Shared package regfile_pkg holds:
  - REG_ZERO=0;
  - default A0_IDX=10, T0_IDX=5, T4_IDX=29 (F1 injection targets);
  - typedef reg_addr_t (logic [ADDRWIDTH-1:0]);
  - typedef reg_data_t (logic [DATAWIDTH-1:0]).
- One sub-module is natural: regfile_scoreboard (busy bit array, set/clear priority, per-port busy lookup). The data array and bypass mux stay in regfile_mp.

Test Plan:
- Reset: write x3=0xDEADBEEF, assert rst_n=0 asynchronously mid-cycle -> rd_data for x3 = 0 immediately; busy all 0; a0=0.
- Register 0 is hardwired: wr_en[0]=1, wr_addr=0, wr_data=0x1234; iss_rd=0 -> reading x0 returns 0, rd_busy=0.
- Bypass:
  - port 0 reads x7 while port 1 writes x7=0xA5A5A5A5 in the same cycle -> rd_data=0xA5A5A5A5 that cycle; dbg_data(x7) shows the old value until the edge.
  - Both write ports write x9 (0x11, 0x22) -> x9=0x22 after the edge.
- Injection priority: inj_valid writes x5=1 and wr_en writes x5=7 in the same cycle -> x5=7. Next cycle inj x29=0x3C alone -> x29=0x3C.
- Scoreboard:
  - iss_valid with iss_rd=12 -> rd_busy=1 on x12 next cycle.
  - A write to x12 with a simultaneous new issue of x12 -> busy stays 1.
  - A later write to x12 alone -> busy=0, and rd_busy=0 during the write cycle itself.
- a0 latency: write x10=0x55 at edge N -> a0=0x55 after edge N+1, not before.
